// File: rtl/shiftadd_pkg.sv
// shiftadd_pkg: shared sizing, scheduler states and in-flight tag type for the reduction scheduler
package shiftadd_pkg;
    localparam int DATA_LENGTH = 64;
    localparam int NUM_CHUNKS = 3;
    localparam int LATENCY = NUM_CHUNKS + 1;
    localparam int ID_W = 3;
    typedef enum logic [1:0] {FLUSH, IDLE, RUN, DRAIN} sched_state_t;
    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } tag_t;
endpackage

// File: rtl/shiftadd_scheduler_if.sv
// shiftadd_scheduler_if: requester bus plus datapath hookup of the shared reduction unit
interface shiftadd_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_LENGTH = shiftadd_pkg::DATA_LENGTH
);
    logic [NUM_REQ-1:0]             req_valid, req_ready, rsp_valid;
    logic [NUM_REQ*DATA_LENGTH-1:0] req_x, req_m, req_m_bl;
    logic [DATA_LENGTH-1:0]         rsp_result, dp_x, dp_m, dp_m_bl, dp_result;
    logic                           dp_start, dp_valid;
    modport master (
        output req_valid, req_x, req_m, req_m_bl, dp_result, dp_valid,
        input  req_ready, rsp_valid, rsp_result, dp_start, dp_x, dp_m, dp_m_bl
    );
    modport slave (
        input  req_valid, req_x, req_m, req_m_bl, dp_result, dp_valid,
        output req_ready, rsp_valid, rsp_result, dp_start, dp_x, dp_m, dp_m_bl
    );
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot grant to the first requester at or after the rotating pointer
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    localparam int IW = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IW-1:0]      idx,
    output logic               any
);
    logic [IW:0] j;
    assign any = |req;
    // scan downwards so the closest requester to the pointer is the last one written
    always_comb begin
        gnt = '0;
        idx = '0;
        j = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            j = {1'b0, ptr} + (IW + 1)'(k);
            j = j >= (IW + 1)'(NUM_REQ) ? j - (IW + 1)'(NUM_REQ) : j;
            if (req[j[IW-1:0]]) begin
                gnt = '0;
                gnt[j[IW-1:0]] = 1'b1;
                idx = j[IW-1:0];
            end
        end
    end
endmodule

// File: rtl/shiftadd_scheduler.sv
// shiftadd_scheduler: round-robin sharing of one pipelined modular-reduction unit,
// keeping the modulus stable while operations are in flight
module shiftadd_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int DATA_LENGTH = shiftadd_pkg::DATA_LENGTH,
    parameter int LATENCY = shiftadd_pkg::LATENCY
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    shiftadd_scheduler_if.slave       bus,
    output logic                      busy_o,
    output logic                      err_o
);
    import shiftadd_pkg::*;
    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(LATENCY + 3);
    localparam int FW = $clog2(LATENCY + 2);
    sched_state_t           state;
    logic [IW-1:0]          ptr, held, win, sel;
    logic [CW-1:0]          cnt;
    logic [FW-1:0]          fcnt;
    logic [DATA_LENGTH-1:0] cfg_m, cfg_m_bl, w_m, w_m_bl;
    logic                   cfg_valid, any, compat, issue, ret, drain, act;
    logic [NUM_REQ-1:0]     gnt;
    tag_t [LATENCY:0]       tags;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req(bus.req_valid),
        .ptr(ptr),
        .gnt(gnt),
        .idx(win),
        .any(any)
    );

    assign w_m = bus.req_m[win*DATA_LENGTH +: DATA_LENGTH];
    assign w_m_bl = bus.req_m_bl[win*DATA_LENGTH +: DATA_LENGTH];
    assign compat = !cfg_valid || (w_m == cfg_m && w_m_bl == cfg_m_bl);
    assign act = state == IDLE || state == RUN;
    assign ret = tags[LATENCY].valid;
    // an incompatible winner only waits when something is still using the current modulus
    assign drain = act && any && !compat && cnt != '0;
    assign bus.req_ready = state == DRAIN ? ((cnt == '0 && bus.req_valid[held]) ? NUM_REQ'(1) << held : '0)
                         : (act && any && (compat || cnt == '0)) ? gnt : '0;
    assign issue = |bus.req_ready;
    assign sel = state == DRAIN ? held : win;
    assign bus.dp_m = cfg_m;
    assign bus.dp_m_bl = cfg_m_bl;
    assign busy_o = cnt != '0 || state != IDLE;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= FLUSH;
            fcnt <= '0;
            cnt <= '0;
            ptr <= '0;
            held <= '0;
            tags <= '0;
            cfg_valid <= 1'b0;
            cfg_m <= '0;
            cfg_m_bl <= '0;
            bus.dp_start <= 1'b0;
            bus.dp_x <= '0;
            bus.rsp_valid <= '0;
            bus.rsp_result <= '0;
            err_o <= 1'b0;
        end else begin
            bus.dp_start <= issue;
            tags <= {tags[LATENCY-1:0], issue, ID_W'(sel)};
            cnt <= cnt + CW'(issue) - CW'(ret);
            bus.rsp_valid <= ret ? NUM_REQ'(1) << tags[LATENCY].id : '0;
            if (ret) bus.rsp_result <= bus.dp_result;
            if (state != FLUSH && bus.dp_valid != ret) err_o <= 1'b1;
            // a compatible issue reloads identical values, so cfg can load on every issue
            if (issue) begin
                bus.dp_x <= bus.req_x[sel*DATA_LENGTH +: DATA_LENGTH];
                cfg_m <= bus.req_m[sel*DATA_LENGTH +: DATA_LENGTH];
                cfg_m_bl <= bus.req_m_bl[sel*DATA_LENGTH +: DATA_LENGTH];
                cfg_valid <= 1'b1;
                ptr <= sel == IW'(NUM_REQ - 1) ? '0 : sel + 1'b1;
            end
            if (drain) held <= win;
            case (state)
                FLUSH: begin
                    fcnt <= fcnt + 1'b1;
                    state <= fcnt == FW'(LATENCY) ? IDLE : FLUSH;
                end
                DRAIN:   state <= cnt != '0 ? DRAIN : issue ? RUN : IDLE;
                default: state <= issue ? RUN : drain ? DRAIN : (!any && cnt == '0) ? IDLE : state;
            endcase
        end
    end
endmodule
